instruction_memory_responder: RTL and testbench
===============================================

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 32-bit instruction words and must be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, sets the number of wait states between request acceptance and response (0..15).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous reset, active-low (0 = in reset).
REQ-005 Port req_valid, input, 1 bit: fetch request present.
REQ-006 Port req_addr, input, [0:31]: byte address of the fetch; bit 0 is the MSB.
REQ-007 Port req_ready, output, 1 bit: responder can accept a request this cycle.
REQ-008 Port rsp_valid, output, 1 bit: rsp_data and rsp_err are valid.
REQ-009 Port rsp_data, output, [0:31]: the instruction word, in big-endian order with opcode in bits [0:5].
REQ-010 Port rsp_err, output, 1 bit: the request was misaligned or out of range.
REQ-011 Port rsp_ready, input, 1 bit: the fetch stage consumes the response.
REQ-012 Port flush, input, 1 bit: taken jump or branch, discard any in-flight fetch.
REQ-013 Ports wr_en (1 bit), wr_addr ([0:31]) and wr_data ([0:31]), all inputs: program-loader word write port.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE, and in RESP in the cycle where rsp_ready=1 (back-to-back acceptance).
REQ-016 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; the word and error status are captured at that edge.
REQ-017 After acceptance, with WAIT_CYCLES=N>0, the block SHALL go to WAIT and load a down-counter with N-1.
- It SHALL move to RESP when the counter is 0.
- With N=0, it SHALL go directly to RESP.
- rsp_valid therefore rises N+1 cycles after acceptance.
REQ-018 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL hold stable until rsp_ready=1.
- Consumption returns the FSM to IDLE.
- If a new request is accepted in the same cycle, the FSM goes to WAIT or RESP instead.
REQ-019 The word index SHALL be req_addr bits [30-log2(DEPTH) : 29].
- rsp_err SHALL be 1 if bits [30:31] are nonzero or any bit above the index is nonzero.
- An erroring request SHALL return rsp_data = 0.
REQ-020 The read SHALL be read-old: a wr_en to the same word on the acceptance edge is not visible in that response.
REQ-021 wr_en SHALL write wr_data to the word at wr_addr on the rising edge.
- Misaligned or out-of-range writes are ignored.
- Writes are accepted in every state.
REQ-022 flush=1 SHALL return the FSM to IDLE on the next edge from any state, cancelling WAIT/RESP without asserting rsp_valid.
- A request presented in the same cycle as flush SHALL NOT be accepted; req_ready is forced to 0 while flush=1.
REQ-023 Simultaneous flush and rsp_ready in RESP SHALL be treated as flush.
REQ-024 The block SHALL have at most one outstanding request.

Reset
REQ-025 reset=0 SHALL immediately force the FSM to IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_err=0 and req_ready=0, regardless of clk.
- Reset asserted mid-WAIT or mid-RESP SHALL discard the transaction.
REQ-026 req_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-027 Memory array contents SHALL NOT be reset; unwritten words read as undefined.

Structure
REQ-028 The shared package dlx_mem_pkg SHALL hold:
- the FSM state encoding;
- DEPTH and WAIT_CYCLES defaults;
- the word-index width function.
REQ-029 Storage SHALL be a sub-module imem_array with one synchronous write port and one registered read port.
- The FSM, counter and address checking stay in the top module.

Verification
REQ-030 Write 0x20010005 to address 0x0, reset released, WAIT_CYCLES=1, request 0x0 with rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rsp_data=0x20010005, rsp_err=0.
REQ-031 Request 0x00000006 -> rsp_err=1, rsp_data=0x00000000; request 0x00000400 with DEPTH=256 -> rsp_err=1.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable throughout, req_ready=0; then rsp_ready=1 with a new req_valid -> back-to-back acceptance that cycle.
REQ-033 Assert flush for one cycle in WAIT -> no rsp_valid for that request, FSM in IDLE, next request served normally.
REQ-034 Write 0xFFFFFFFF to word 4 on the same edge a request to 0x10 is accepted (old value 0x00000000) -> response is 0x00000000; the next request to 0x10 returns 0xFFFFFFFF.
REQ-035 Drive reset low asynchronously (between clk edges) in RESP -> rsp_valid drops to 0 before the next edge; after release, req_ready=1 and the memory retains its contents.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the instruction fetch responder:
// FSM encoding, default sizing and the word-index width helper.
package dlx_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetchState_t;

    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Wait-state counter width, large enough for 0..15
    localparam int CNT_W = 4;

    // Number of address bits needed to select one of 'depth' words
    function automatic int wordIndexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and one registered
// read port. The read register only updates when rdEn is high, so it holds
// the fetched word for as long as the response is outstanding. Contents are
// deliberately left unreset.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrIdx,
    input  logic [31:0]   wrData,
    input  logic          rdEn,
    input  logic [AW-1:0] rdIdx,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH];

    // Write and read on the same edge; the read sees the pre-write word
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdIdx];
        end
    end

endmodule

// File: rtl/instruction_memory_responder.sv
// Instruction fetch responder: accepts one fetch at a time, waits a fixed
// number of cycles, then presents the word (or an error) until consumed.
// Address/bus vectors use big-endian bit numbering ([0:31], bit 0 = MSB);
// internally they are viewed as ordinary [31:0] values.
module instruction_memory_responder
    import dlx_mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [0:31] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [0:31] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [0:31] wr_addr,
    input  logic [0:31] wr_data
);

    localparam int AW = wordIndexWidth(DEPTH);

    // Counter preload and target state used whenever a request is accepted
    localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam fetchState_t      LAUNCH_STATE = (WAIT_CYCLES > 0) ? WAIT : RESP;

    // True when the byte address is misaligned or beyond the array
    function automatic logic addrBad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    // Word index taken just above the byte-offset bits
    function automatic logic [AW-1:0] addrIdx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    fetchState_t      stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             errQ;
    logic             accept;
    logic             wrOk;
    logic [31:0]      reqAddrLe;
    logic [31:0]      wrAddrLe;
    logic [31:0]      rdData;

    assign reqAddrLe = req_addr;
    assign wrAddrLe  = wr_addr;

    // Ready only when idle or when the pending response retires this cycle;
    // flush and reset both block acceptance
    always_comb begin
        req_ready = 1'b0;
        if (reset && !flush) begin
            req_ready = (stateQ == IDLE) || ((stateQ == RESP) && rsp_ready);
        end
    end

    assign accept = req_valid && req_ready;
    assign wrOk   = wr_en && !addrBad(wrAddrLe);

    // Next-state and wait counter; flush overrides everything, including
    // a simultaneous consume in RESP
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (flush) begin
            stateD = IDLE;
            cntD   = '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (accept) begin
                        stateD = LAUNCH_STATE;
                        cntD   = WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (cntQ == '0) begin
                        stateD = RESP;
                    end else begin
                        cntD = cntQ - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (accept) begin
                            stateD = LAUNCH_STATE;
                            cntD   = WAIT_LOAD;
                        end else begin
                            stateD = IDLE;
                        end
                    end
                end
                default: begin
                    stateD = IDLE;
                    cntD   = '0;
                end
            endcase
        end
    end

    // FSM, counter and captured error status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                errQ <= addrBad(reqAddrLe);
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uArray (
        .clk    (clk),
        .wrEn   (wrOk),
        .wrIdx  (addrIdx(wrAddrLe)),
        .wrData (wr_data),
        .rdEn   (accept),
        .rdIdx  (addrIdx(reqAddrLe)),
        .rdData (rdData)
    );

    // Response outputs; data is zeroed for errors and whenever no response
    // is presented, so reset clears it immediately
    always_comb begin
        rsp_valid = (stateQ == RESP);
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (stateQ == RESP) begin
            rsp_err = errQ;
            if (!errQ) begin
                rsp_data = rdData;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Directed bench for instruction_memory_responder (DEPTH=256, WAIT_CYCLES=1).
module tb_instruction_memory_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [0:31] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [0:31] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        flush;
    logic        wr_en;
    logic [0:31] wr_addr;
    logic [0:31] wr_data;

    int errors = 0;
    int checks = 0;

    instruction_memory_responder #(
        .DEPTH       (256),
        .WAIT_CYCLES (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one rising edge; outputs are settled on return
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    // Issue one fetch with rsp_ready=1; report data, error and latency
    // (-1 if no response within the cycle budget)
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
        d = rsp_data;
        e = rsp_err;
        step();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        step();
        step();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_held_req_ready got=%b exp=0", req_ready); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got=%b exp=1", req_ready); end
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_release_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_basic();
        loadWord(32'h0, 32'h20010005);
        loadWord(32'h4, 32'h11223344);
        loadWord(32'h3FC, 32'hCAFEBABE);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_cycle1_valid got=%b exp=0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_cycle2_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 32'h20010005) begin errors++; $display("FAIL basic_data got=%h exp=20010005", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", rsp_err); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        int          lat;
        fetch(32'h6, d, e, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_latency got=%0d exp=2", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misalign_data got=%h exp=0", d); end
        fetch(32'h400, d, e, lat);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL range_data got=%h exp=0", d); end
        fetch(32'h3FC, d, e, lat);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL top_word_err got=%b exp=0", e); end
        checks++; if (d !== 32'hCAFEBABE) begin errors++; $display("FAIL top_word_data got=%h exp=cafebabe", d); end
        fetch(32'h80000000, d, e, lat);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL msb_addr_err got=%b exp=1", e); end
        loadWord(32'h5, 32'hDEADBEEF);
        loadWord(32'h404, 32'h55555555);
        fetch(32'h4, d, e, lat);
        checks++; if (d !== 32'h11223344) begin errors++; $display("FAIL bad_write_ignored got=%h exp=11223344", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL word1_err got=%b exp=0", e); end
    endtask

    task automatic test_stall();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_enter_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 32'h11223344) begin errors++; $display("FAIL stall_enter_data got=%h exp=11223344", rsp_data); end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, rsp_valid); end
            checks++; if (rsp_data !== 32'h11223344) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=11223344", i, rsp_data); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d] got=%b exp=0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_wait_valid got=%b exp=0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 32'h20010005) begin errors++; $display("FAIL b2b_data got=%h exp=20010005", rsp_data); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic        e;
        int          lat;
        // flush while waiting
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_wait_req_ready got=%b exp=0", req_ready); end
        step();
        flush = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_valid0 got=%b exp=0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_valid1 got=%b exp=0", rsp_valid); end
        fetch(32'h4, d, e, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_flush_latency got=%0d exp=2", lat); end
        checks++; if (d !== 32'h11223344) begin errors++; $display("FAIL post_flush_data got=%h exp=11223344", d); end
        // request alongside flush in IDLE is refused
        req_valid = 1'b1;
        req_addr  = 32'h0;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_req_ready got=%b exp=0", req_ready); end
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_no_rsp got=%b exp=0", rsp_valid); end
        // flush beats a consume in RESP
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_resp_pre_valid got=%b exp=1", rsp_valid); end
        flush     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_resp_req_ready got=%b exp=0", req_ready); end
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_valid0 got=%b exp=0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_valid1 got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_read_old();
        logic [31:0] d;
        logic        e;
        int          lat;
        loadWord(32'h10, 32'h0);
        req_valid = 1'b1;
        req_addr  = 32'h10;
        rsp_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 32'h10;
        wr_data   = 32'hFFFFFFFF;
        step();
        wr_en     = 1'b0;
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_old_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL read_old_data got=%h exp=00000000", rsp_data); end
        step();
        fetch(32'h10, d, e, lat);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL read_new_data got=%h exp=ffffffff", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        e;
        int          lat;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", rsp_valid); end
        #4;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL areset_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL areset_data got=%h exp=0", rsp_data); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_held_valid got=%b exp=0", rsp_valid); end
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL areset_release_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_release_valid got=%b exp=0", rsp_valid); end
        fetch(32'h0, d, e, lat);
        checks++; if (d !== 32'h20010005) begin errors++; $display("FAIL retain_word0 got=%h exp=20010005", d); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL retain_latency got=%0d exp=2", lat); end
        fetch(32'h3FC, d, e, lat);
        checks++; if (d !== 32'hCAFEBABE) begin errors++; $display("FAIL retain_word255 got=%h exp=cafebabe", d); end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        test_reset();
        test_basic();
        test_errors();
        test_stall();
        test_flush();
        test_read_old();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
